// File: rtl/audio_clip_multi_if.sv
// Bus bundle for the N-channel audio clipper: frame slot, threshold, sample
// buses and status outputs. master = audio path driver, slave = clipper.
interface audio_clip_multi_if #(
    parameter int DATA_W = 16,
    parameter int NCH    = 2
);
    logic [7:0]            cnt256_n;
    logic [DATA_W-2:0]     thr;
    logic [NCH*DATA_W-1:0] ch_in;
    logic [NCH*DATA_W-1:0] ch_out;
    logic [NCH-1:0]        clip_flag;
    logic                  out_valid;
    logic                  busy;
    logic [15:0]           clip_cnt;

    modport master (
        output cnt256_n, thr, ch_in,
        input  ch_out, clip_flag, out_valid, busy, clip_cnt
    );

    modport slave (
        input  cnt256_n, thr, ch_in,
        output ch_out, clip_flag, out_valid, busy, clip_cnt
    );
endinterface

// File: rtl/audio_clip_multi.sv
// N-channel hard clipper: snapshots a frame on START_SLOT, clips one channel per
// clock through a shared comparator, presents on OUT_SLOT. Optional macro: CLIP_CNT_EN.
module audio_clip_multi #(
    parameter int DATA_W     = 16,
    parameter int NCH        = 2,
    parameter int START_SLOT = 0,
    parameter int OUT_SLOT   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    audio_clip_multi_if.slave bus
);
    localparam int         IDX_W    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [7:0] START_U  = 8'(START_SLOT);
    localparam logic [7:0] OUT_U    = 8'(OUT_SLOT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        PROC = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [DATA_W-2:0] thr_s_reg;

    logic start_slot;
    logic out_slot;
    logic proc_step;
    logic last_step;
    logic out_valid_reg;

    logic [NCH*DATA_W-1:0] snap_flat;
    logic [DATA_W-1:0]     cur_x;
    logic [DATA_W-1:0]     hi_lim;
    logic [DATA_W-1:0]     lo_lim;
    logic [DATA_W-1:0]     clip_y;
    logic                  clip_f;

    assign start_slot = (bus.cnt256_n == START_U);
    assign out_slot   = (bus.cnt256_n == OUT_U);
    // A start slot always wins over processing, which is what aborts a frame in flight.
    assign proc_step  = (state_reg == PROC) && !start_slot;
    assign last_step  = proc_step && (idx_reg == LAST_IDX);

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        if (start_slot) begin
            state_next = PROC;
            idx_next   = '0;
        end else if (state_reg == PROC) begin
            if (idx_reg == LAST_IDX) begin
                state_next = IDLE;
                idx_next   = '0;
            end else begin
                idx_next = idx_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            thr_s_reg     <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            out_valid_reg <= out_slot;
            if (start_slot) begin
                thr_s_reg <= bus.thr;
            end
        end
    end

    // Shared comparator: the current channel is selected from the snapshot by idx.
    always_comb begin
        cur_x = '0;
        for (int k = 0; k < NCH; k++) begin
            if (idx_reg == IDX_W'(k)) begin
                cur_x = snap_flat[k*DATA_W +: DATA_W];
            end
        end
    end

    // -thr-1 is the bitwise complement of the zero-extended threshold.
    assign hi_lim = {1'b0, thr_s_reg};
    assign lo_lim = ~hi_lim;

    always_comb begin
        clip_y = cur_x;
        clip_f = 1'b0;
        if ($signed(cur_x) > $signed(hi_lim)) begin
            clip_y = hi_lim;
            clip_f = 1'b1;
        end else if ($signed(cur_x) < $signed(lo_lim)) begin
            clip_y = lo_lim;
            clip_f = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [DATA_W-1:0] snap_reg;
            logic [DATA_W-1:0] work_reg;
            logic [DATA_W-1:0] commit_reg;
            logic [DATA_W-1:0] out_reg;
            logic              wflag_reg;
            logic              cflag_reg;
            logic              oflag_reg;
            logic              hit;

            assign hit = proc_step && (idx_reg == IDX_W'(gi));

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    snap_reg   <= '0;
                    work_reg   <= '0;
                    commit_reg <= '0;
                    out_reg    <= '0;
                    wflag_reg  <= 1'b0;
                    cflag_reg  <= 1'b0;
                    oflag_reg  <= 1'b0;
                end else begin
                    if (start_slot) begin
                        snap_reg <= bus.ch_in[gi*DATA_W +: DATA_W];
                    end
                    if (hit) begin
                        work_reg  <= clip_y;
                        wflag_reg <= clip_f;
                    end
                    // The channel being clipped on the last step bypasses the work buffer.
                    if (last_step) begin
                        commit_reg <= hit ? clip_y : work_reg;
                        cflag_reg  <= hit ? clip_f : wflag_reg;
                    end
                    if (out_slot) begin
                        out_reg   <= commit_reg;
                        oflag_reg <= cflag_reg;
                    end
                end
            end

            assign snap_flat[gi*DATA_W +: DATA_W]  = snap_reg;
            assign bus.ch_out[gi*DATA_W +: DATA_W] = out_reg;
            assign bus.clip_flag[gi]               = oflag_reg;
        end
    endgenerate

    assign bus.out_valid = out_valid_reg;
    assign bus.busy      = (state_reg == PROC);

`ifdef CLIP_CNT_EN
    logic [15:0] clip_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clip_cnt_reg <= 16'h0000;
        end else if (proc_step && clip_f && (clip_cnt_reg != 16'hFFFF)) begin
            clip_cnt_reg <= clip_cnt_reg + 16'h0001;
        end
    end

    assign bus.clip_cnt = clip_cnt_reg;
`else
    assign bus.clip_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_audio_clip_multi.sv
// Self-checking bench for audio_clip_multi: randomized frames against a
// behavioural clip model; covers reset, boundaries, abort and the clip counter.
module tb_audio_clip_multi;
    localparam int DATA_W     = 16;
    localparam int NCH        = 8;
    localparam int START_SLOT = 0;
    localparam int OUT_SLOT   = 12;
`ifdef CLIP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [NCH*DATA_W-1:0] exp_out;
    logic [NCH-1:0]        exp_flag;
    int                    total_clips;

    audio_clip_multi_if #(.DATA_W(DATA_W), .NCH(NCH)) bus ();

    audio_clip_multi #(
        .DATA_W(DATA_W), .NCH(NCH), .START_SLOT(START_SLOT), .OUT_SLOT(OUT_SLOT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic adv();
        tick();
        bus.cnt256_n = bus.cnt256_n + 8'd1;
    endtask

    function automatic int exp_cnt();
        if (!CNT_EN) return 0;
        return (total_clips > 65535) ? 65535 : total_clips;
    endfunction

    // Clip model from plain signed integer arithmetic.
    task automatic model_frame(input logic [NCH*DATA_W-1:0] ch, input logic [DATA_W-2:0] t,
                               output logic [NCH*DATA_W-1:0] y, output logic [NCH-1:0] f);
        int xi, hi, lo, yi;
        y = '0;
        f = '0;
        hi = int'(t);
        lo = -hi - 1;
        for (int k = 0; k < NCH; k++) begin
            xi = $signed(ch[k*DATA_W +: DATA_W]);
            yi = xi;
            if (xi > hi) begin yi = hi; f[k] = 1'b1; end
            else if (xi < lo) begin yi = lo; f[k] = 1'b1; end
            y[k*DATA_W +: DATA_W] = yi[DATA_W-1:0];
        end
    endtask

    function automatic logic [NCH*DATA_W-1:0] rand_frame();
        logic [NCH*DATA_W-1:0] v;
        for (int k = 0; k < NCH; k++) v[k*DATA_W +: DATA_W] = DATA_W'($urandom);
        return v;
    endfunction

    // Walks to OUT_SLOT, lets it load, then checks the presented frame and pulse shape.
    task automatic present_and_check(input string name);
        int guard = 0;
        while (bus.cnt256_n != 8'(OUT_SLOT) && guard < 300) begin adv(); guard++; end
        checks++;
        if (guard >= 300) begin errors++; $display("FAIL %s_out_timeout got %0d exp <300", name, guard); end
        adv();
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL %s_valid got %b exp 1", name, bus.out_valid); end
        checks++;
        if (bus.ch_out !== exp_out) begin errors++; $display("FAIL %s_ch_out got %h exp %h", name, bus.ch_out, exp_out); end
        checks++;
        if (bus.clip_flag !== exp_flag) begin errors++; $display("FAIL %s_flag got %b exp %b", name, bus.clip_flag, exp_flag); end
        checks++;
        if (int'(bus.clip_cnt) !== exp_cnt()) begin errors++; $display("FAIL %s_clip_cnt got %0d exp %0d", name, bus.clip_cnt, exp_cnt()); end
        adv();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.ch_out !== exp_out) begin
            errors++;
            $display("FAIL %s_hold got valid=%b out=%h exp valid=0 out=%h", name, bus.out_valid, bus.ch_out, exp_out);
        end
        $display("frame %s thr-frame out=%h flag=%b clip_cnt=%0d", name, bus.ch_out, bus.clip_flag, bus.clip_cnt);
    endtask

    task automatic run_frame(input string name, input logic [NCH*DATA_W-1:0] ch,
                             input logic [DATA_W-2:0] t_start, input logic [DATA_W-2:0] t_after);
        int guard = 0;
        int busy_n = 0;
        while (bus.cnt256_n != 8'(START_SLOT) && guard < 300) begin adv(); guard++; end
        checks++;
        if (guard >= 300) begin errors++; $display("FAIL %s_start_timeout got %0d exp <300", name, guard); end
        bus.ch_in = ch;
        bus.thr   = t_start;
        model_frame(ch, t_start, exp_out, exp_flag);
        total_clips += $countones(exp_flag);
        adv();
        bus.ch_in = rand_frame();
        bus.thr   = t_after;
        guard = 0;
        while (bus.cnt256_n != 8'(OUT_SLOT) && guard < 300) begin
            if (bus.busy) busy_n++;
            adv();
            guard++;
        end
        checks++;
        if (busy_n !== NCH) begin errors++; $display("FAIL %s_busy_cycles got %0d exp %0d", name, busy_n, NCH); end
        present_and_check(name);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.ch_out !== '0 || bus.clip_flag !== '0 || bus.out_valid !== 1'b0 ||
            bus.busy !== 1'b0 || bus.clip_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset got out=%h flag=%b valid=%b busy=%b cnt=%h exp all zero",
                     bus.ch_out, bus.clip_flag, bus.out_valid, bus.busy, bus.clip_cnt);
        end
        rst_n = 1'b1;
        total_clips = 0;
        $display("reset released");
    endtask

    task automatic test_basic();
        logic [NCH*DATA_W-1:0] ch = rand_frame();
        ch[15:0]  = 16'h3000;
        ch[31:16] = 16'h1000;
        run_frame("basic", ch, 15'h1FFF, 15'h1FFF);
        checks++;
        if (bus.ch_out[31:0] !== 32'h1000_1FFF || bus.clip_flag[1:0] !== 2'b01) begin
            errors++;
            $display("FAIL basic_vector got %h/%b exp 10001fff/01", bus.ch_out[31:0], bus.clip_flag[1:0]);
        end
    endtask

    task automatic test_neg_boundary();
        logic [NCH*DATA_W-1:0] ch = rand_frame();
        ch[15:0]  = 16'h8000;
        ch[31:16] = 16'hE000;
        run_frame("neg_boundary", ch, 15'h1FFF, 15'h0);
        checks++;
        if (bus.ch_out[31:0] !== 32'hE000_E000 || bus.clip_flag[1:0] !== 2'b01) begin
            errors++;
            $display("FAIL neg_vector got %h/%b exp e000e000/01", bus.ch_out[31:0], bus.clip_flag[1:0]);
        end
    endtask

    task automatic test_thr_zero();
        logic [NCH*DATA_W-1:0] ch = rand_frame();
        ch[15:0]  = 16'h0001;
        ch[31:16] = 16'hFFFE;
        run_frame("thr_zero", ch, 15'h0, 15'h7FFF);
        checks++;
        if (bus.ch_out[31:0] !== 32'hFFFF_0000 || bus.clip_flag[1:0] !== 2'b11) begin
            errors++;
            $display("FAIL zero_vector got %h/%b exp ffff0000/11", bus.ch_out[31:0], bus.clip_flag[1:0]);
        end
    endtask

    task automatic test_thr_midframe();
        logic [NCH*DATA_W-1:0] ch = rand_frame();
        ch[15:0] = 16'h0800;
        run_frame("thr_mid_a", ch, 15'h1FFF, 15'h0100);
        checks++;
        if (bus.ch_out[15:0] !== 16'h0800) begin errors++; $display("FAIL thr_mid_a got %h exp 0800", bus.ch_out[15:0]); end
        run_frame("thr_mid_b", ch, 15'h0100, 15'h0100);
        checks++;
        if (bus.ch_out[15:0] !== 16'h0100) begin errors++; $display("FAIL thr_mid_b got %h exp 0100", bus.ch_out[15:0]); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            logic [DATA_W-2:0] t = 15'($urandom) >> $urandom_range(0, 10);
            run_frame($sformatf("rand%0d", n), rand_frame(), t, 15'($urandom));
        end
    endtask

    task automatic test_abort();
        logic [NCH*DATA_W-1:0] ch_a = rand_frame();
        logic [NCH*DATA_W-1:0] ya;
        logic [NCH-1:0]        fa;
        int guard = 0;
        while (bus.cnt256_n != 8'(START_SLOT) && guard < 300) begin adv(); guard++; end
        bus.ch_in = ch_a;
        bus.thr   = 15'h0040;
        model_frame(ch_a, 15'h0040, ya, fa);
        adv();
        adv();
        adv();
        // Two channels of frame A were clipped before the restart.
        total_clips += int'(fa[0]) + int'(fa[1]);
        bus.cnt256_n = 8'(START_SLOT);
        run_frame("abort_b", rand_frame(), 15'h0200, 15'h0);
    endtask

    task automatic test_reset_mid_proc();
        int guard = 0;
        while (bus.cnt256_n != 8'(START_SLOT) && guard < 300) begin adv(); guard++; end
        bus.ch_in = rand_frame();
        bus.thr   = 15'h0010;
        adv();
        adv();
        adv();
        rst_n = 1'b0;
        adv();
        rst_n = 1'b1;
        checks++;
        if (bus.ch_out !== '0 || bus.clip_flag !== '0 || bus.out_valid !== 1'b0 ||
            bus.busy !== 1'b0 || bus.clip_cnt !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset got out=%h flag=%b valid=%b busy=%b cnt=%h exp all zero",
                     bus.ch_out, bus.clip_flag, bus.out_valid, bus.busy, bus.clip_cnt);
        end
        total_clips = 0;
        exp_out     = '0;
        exp_flag    = '0;
        present_and_check("post_reset_empty");
        run_frame("post_reset", rand_frame(), 15'h0400, 15'h0);
    endtask

    // Back-to-back minimal frames, every channel clipping, never touching OUT_SLOT.
    task automatic test_clip_cnt();
        int frames = CNT_EN ? ((65535 - total_clips) / NCH + 2) : 20;
        for (int n = 0; n < frames; n++) begin
            bus.cnt256_n = 8'(START_SLOT);
            bus.thr      = 15'h0;
            for (int k = 0; k < NCH; k++) bus.ch_in[k*DATA_W +: DATA_W] = 16'h7FFF;
            tick();
            for (int j = 1; j <= NCH; j++) begin
                bus.cnt256_n = 8'(START_SLOT + j);
                tick();
            end
            total_clips += NCH;
        end
        checks++;
        if (int'(bus.clip_cnt) !== exp_cnt()) begin
            errors++;
            $display("FAIL clip_cnt_sat got %0d exp %0d", bus.clip_cnt, exp_cnt());
        end
        $display("clip_cnt after %0d fast frames = %0d", frames, bus.clip_cnt);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.cnt256_n = 8'd100;
        bus.thr      = '0;
        bus.ch_in    = '0;
        exp_out      = '0;
        exp_flag     = '0;
        total_clips  = 0;
        test_reset();
        test_basic();
        test_neg_boundary();
        test_thr_zero();
        test_thr_midframe();
        test_random();
        test_abort();
        test_reset_mid_proc();
        test_clip_cnt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
